fetch_pc_btb: RTL and testbench
===============================

# fetch_pc_btb

Parametrised fetch PC generator for the IF stage, with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it holds the current fetch PC and predicts the next one. It resolves redirects by priority: trap, then EX correction, then BTB prediction, then sequential. It trains the BTB from branch outcomes resolved in EX.

## Interface
Parameters:
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, ≥2.
- `IDX_W`, `$clog2(BTB_ENTRIES)`: derived index width; not to be overridden.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_en`  in  1  global PC update enable; low freezes the PC.
- `pc_stall`  in  1  hazard stall; blocks predicted and sequential advance only.
- `trap_redirect`  in  1  trap or exception redirect request.
- `trap_target`  in  XLEN  trap redirect address.
- `ex_redirect`  in  1  mispredict correction from EX.
- `ex_target`  in  XLEN  corrected PC.
- `upd_valid`  in  1  resolved control-transfer instruction in EX; train the BTB.
- `upd_pc`  in  XLEN  PC of the resolved instruction.
- `upd_taken`  in  1  actual branch outcome.
- `upd_target`  in  XLEN  actual branch target.
- `btb_flush`  in  1  invalidate all entries (`fence.i`).
- `pc`  out  XLEN  current fetch PC.
- `pc_plus4`  out  XLEN  `pc + 4`.
- `pred_taken`  out  1  BTB predicts taken for `pc`.
- `pred_target`  out  XLEN  predicted target; valid only when `pred_taken`.

`XLEN` and `RESET_PC` come from `riscv_pkg`.

## Operation
- **Address split:**
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[XLEN-1:IDX_W+2]`
  - bits [1:0] are ignored.
- **Entry contents:** `valid`, `tag`, `target`, `ctr[1:0]`.
- **Lookup (combinational on `pc`):**
  - hit = `valid[idx] && tag match`.
  - `pred_taken` = hit && `ctr[1]`.
  - `pred_target` = stored target.
- **Next-PC priority:** `trap_redirect` > `ex_redirect` > `pred_taken` > `pc_plus4`.
- **PC register update:**
  - `pc_en`=0: hold, regardless of any other input.
  - `pc_en`=1, any redirect asserted: load the redirect target, even when `pc_stall`=1. A flush beats a stall.
  - `pc_en`=1, `pc_stall`=1, no redirect: hold.
  - Otherwise: load the predicted target or `pc_plus4`.
- **Training (independent of `pc_en` and `pc_stall`), when `upd_valid`:**
  - Hit on `upd_pc`, taken: ctr saturating +1, target overwritten with `upd_target`.
  - Hit, not taken: ctr saturating −1; target unchanged.
  - Miss, taken: allocate (replacing any occupant): `valid`=1, tag, target, `ctr`=2'b10.
  - Miss, not taken: no change.
- **`btb_flush`:** clears every valid bit at the next edge. A simultaneous `upd_valid` is dropped.
- **Arithmetic:** `pc_plus4` wraps modulo 2^XLEN. Targets are stored and used unmodified; no alignment forcing.

## Timing
- **Reset:**
  - `pc` = `RESET_PC` after the first edge with `reset`=1.
  - All valid bits are cleared, so `pred_taken`=0 and `pred_target` is don't-care.
  - `ctr` and target arrays need no reset.
  - Reset asserted mid-operation overrides every other input in that cycle, including any update.
- **Latency:**
  - `pc`, `pc_plus4`, `pred_taken` and `pred_target` are combinational from the `pc` register, with zero-cycle lookup.
  - A redirect asserted in cycle N appears on `pc` in cycle N+1.
- **Training visibility:** an update at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the index being written sees the old entry (no bypass).
- **Counter boundaries:** `ctr` saturates at 2'b11 and 2'b00; it never wraps.
- **Simultaneous `trap_redirect` and `ex_redirect`:** `trap_target` wins. The `ex_redirect` is not queued.

## Structure
- **`riscv_pkg` additions:**
  - `btb_entry_t`: packed struct (`valid`, `tag`, `target`, `ctr`). Tag width is a function of `IDX_W`, so the tag may instead be typed locally.
  - `bp_ctr_t` constants: `SNT`=00, `WNT`=01, `WT`=10, `ST`=11.
- **Sub-module `btb_dm`:** storage, lookup, training and flush. `fetch_pc_btb` keeps only the PC register and the next-PC mux.
- **Storage:** flop arrays, not SRAM, because the read is asynchronous.

## Test plan
1. **Reset, then free run:** `reset` for 2 cycles, `pc_en`=1 → `pc`=`RESET_PC`, then +4 per cycle; `pred_taken`=0 throughout.
2. **Allocate and predict:**
   - Stimulus: `upd_valid`, `upd_pc`=0x100, `upd_taken`=1, `upd_target`=0x200.
   - Response: the next time `pc`=0x100, `pred_taken`=1, `pred_target`=0x200, and the following `pc`=0x200.
3. **Counter training:**
   - Stimulus: three not-taken updates on 0x100 (`ctr` 10→01→00→00), then one taken update.
   - Response: `ctr`=01 and `pred_taken`=0 at 0x100; `pc` advances to 0x104.
4. **Priority:**
   - Stimulus: `pc_stall`=1 with `trap_redirect` (0x80) and `ex_redirect` (0x300) in the same cycle.
   - Response: `pc`=0x80 next cycle.
   - Follow-up: `pc_stall` alone holds the PC; `pc_en`=0 with `trap_redirect` holds the PC.
5. **Aliasing:**
   - Setup: BTB_ENTRIES=16; 0x100 allocated.
   - Stimulus: taken update on 0x140 (same index, different tag).
   - Response: lookup at 0x100 misses and 0x140 hits.
6. **Flush collision:**
   - Stimulus: `btb_flush` together with `upd_valid` for a new taken branch.
   - Response: all lookups miss afterwards; the update is not allocated.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants plus branch-predictor types used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
    return (c == ST) ? ST : bp_ctr_t'(c + 2'b01);
  endfunction

  function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
    return (c == SNT) ? SNT : bp_ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped BTB with 2-bit direction counters: async lookup, trained from EX.
module btb_dm
  import riscv_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    bp_ctr_t          ctr;
  } btb_entry_t;

  // Only the valid bits are reset; tags, targets and counters are qualified by them.
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  bp_ctr_t                ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0] rd_tag, up_tag;
  btb_entry_t       rd_e, up_e, wr_e;
  logic             wr_en;
  logic [3:0]       unused_lsb;

  assign rd_idx     = lookup_pc[IDX_W+1:2];
  assign rd_tag     = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[XLEN-1:IDX_W+2];
  assign unused_lsb = {lookup_pc[1:0], upd_pc[1:0]};

  assign rd_e = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx],
                  target: target_q[rd_idx], ctr: ctr_q[rd_idx]};
  assign up_e = '{valid: valid_q[up_idx], tag: tag_q[up_idx],
                  target: target_q[up_idx], ctr: ctr_q[up_idx]};

  assign pred_taken  = rd_e.valid && (rd_e.tag == rd_tag) && rd_e.ctr[1];
  assign pred_target = rd_e.target;

  always_comb begin
    wr_en     = 1'b0;
    wr_e      = up_e;
    wr_e.valid = 1'b1;
    wr_e.tag  = up_tag;
    // Flush and reset both drop a coincident training update.
    if (upd_valid && !flush && !reset) begin
      if (up_e.valid && (up_e.tag == up_tag)) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_e.ctr    = ctr_inc(up_e.ctr);
          wr_e.target = upd_target;
        end else begin
          wr_e.ctr = ctr_dec(up_e.ctr);
        end
      end else if (upd_taken) begin
        wr_en       = 1'b1;
        wr_e.target = upd_target;
        wr_e.ctr    = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[up_idx] <= wr_e.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_idx]    <= wr_e.tag;
      target_q[up_idx] <= wr_e.target;
      ctr_q[up_idx]    <= wr_e.ctr;
    end
  end

endmodule

// File: rtl/fetch_pc_btb.sv
// IF-stage fetch PC register and next-PC select: trap > EX correction > BTB > pc+4.
module fetch_pc_btb
  import riscv_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_en,
  input  logic            pc_stall,
  input  logic            trap_redirect,
  input  logic [XLEN-1:0] trap_target,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            btb_flush,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] pc_q, pc_d;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);

  btb_dm #(
    .BTB_ENTRIES(BTB_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (pc_q),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (btb_flush)
  );

  // Redirects are flushes and must win over a hazard stall.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      if (trap_redirect) begin
        pc_d = trap_target;
      end else if (ex_redirect) begin
        pc_d = ex_target;
      end else if (!pc_stall) begin
        pc_d = pred_taken ? pred_target : pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Table-driven bench for fetch_pc_btb; expected post-edge outputs go through a scoreboard queue.
module tb_fetch_pc_btb;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pc_en, pc_stall, trap_redirect, ex_redirect;
  logic [31:0] trap_target, ex_target, upd_pc, upd_target;
  logic        upd_valid, upd_taken, btb_flush;
  logic [31:0] pc, pc_plus4, pred_target;
  logic        pred_taken;

  always #5 clk = ~clk;

  fetch_pc_btb #(.BTB_ENTRIES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_en        (pc_en),
    .pc_stall     (pc_stall),
    .trap_redirect(trap_redirect),
    .trap_target  (trap_target),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .btb_flush    (btb_flush),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target)
  );

  typedef struct {
    logic        rst, en, stall, trap, ex, uv, ut, fl;
    logic [31:0] trap_t, ex_t, upc, utgt;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t row(input logic [31:0] p, input logic t = 1'b0,
                               input logic [31:0] g = 32'h0);
    vec_t v;
    v = '{default: '0};
    v.en = 1'b1; v.e_pc = p; v.e_pt = t; v.e_tgt = g;
    return v;
  endfunction
  function automatic vec_t tr(input vec_t v, input logic [31:0] a);
    v.trap = 1'b1; v.trap_t = a; return v;
  endfunction
  function automatic vec_t exr(input vec_t v, input logic [31:0] a);
    v.ex = 1'b1; v.ex_t = a; return v;
  endfunction
  function automatic vec_t upd(input vec_t v, input logic [31:0] p, input logic t,
                               input logic [31:0] g);
    v.uv = 1'b1; v.upc = p; v.ut = t; v.utgt = g; return v;
  endfunction
  function automatic vec_t rst(input vec_t v);   v.rst = 1'b1;   return v; endfunction
  function automatic vec_t stl(input vec_t v);   v.stall = 1'b1; return v; endfunction
  function automatic vec_t hold(input vec_t v);  v.en = 1'b0;    return v; endfunction
  function automatic vec_t fl(input vec_t v);    v.fl = 1'b1;    return v; endfunction

  task automatic check32(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic check1(input string nm, input int id, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b want %b", nm, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    reset = v.rst; pc_en = v.en; pc_stall = v.stall;
    trap_redirect = v.trap; trap_target = v.trap_t;
    ex_redirect = v.ex; ex_target = v.ex_t;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
    btb_flush = v.fl;
    e.id = id; e.pc = v.e_pc; e.pt = v.e_pt; e.tg = v.e_tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check32("pc", e.id, pc, e.pc);
    check32("pc_plus4", e.id, pc_plus4, e.pc + 32'd4);
    check1("pred_taken", e.id, pred_taken, e.pt);
    if (e.pt) check32("pred_target", e.id, pred_target, e.tg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_en = 1'b0; pc_stall = 1'b0;
    trap_redirect = 1'b0; trap_target = '0; ex_redirect = 1'b0; ex_target = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; btb_flush = 1'b0;

    // reset then free run
    vecs.push_back(rst(row(RESET_PC)));
    vecs.push_back(rst(row(RESET_PC)));
    vecs.push_back(row(RESET_PC + 32'd4));
    vecs.push_back(row(RESET_PC + 32'd8));
    vecs.push_back(row(RESET_PC + 32'd12));
    // allocate 0x100 -> 0x200 and follow the prediction
    vecs.push_back(upd(tr(row(32'h100, 1'b1, 32'h200), 32'h100), 32'h100, 1'b1, 32'h200));
    vecs.push_back(row(32'h200));
    vecs.push_back(row(32'h204));
    // 10 -> 01 -> 00 -> 00 -> 01
    vecs.push_back(upd(row(32'h208), 32'h100, 1'b0, 32'h0));
    vecs.push_back(upd(row(32'h20C), 32'h100, 1'b0, 32'h0));
    vecs.push_back(upd(row(32'h210), 32'h100, 1'b0, 32'h0));
    vecs.push_back(upd(row(32'h214), 32'h100, 1'b1, 32'h200));
    vecs.push_back(tr(row(32'h100), 32'h100));
    vecs.push_back(row(32'h104));
    // priority, stall and enable
    vecs.push_back(exr(stl(tr(row(32'h80), 32'h80)), 32'h300));
    vecs.push_back(stl(row(32'h80)));
    vecs.push_back(tr(hold(row(32'h80)), 32'h400));
    vecs.push_back(hold(row(32'h80)));
    vecs.push_back(exr(stl(row(32'h300)), 32'h300));
    vecs.push_back(row(32'h304));
    // aliasing on index 0, no same-cycle bypass
    vecs.push_back(upd(row(32'h308), 32'h100, 1'b1, 32'h200));
    vecs.push_back(tr(row(32'h100, 1'b1, 32'h200), 32'h100));
    vecs.push_back(upd(row(32'h200), 32'h140, 1'b1, 32'h500));
    vecs.push_back(tr(row(32'h100), 32'h100));
    vecs.push_back(tr(row(32'h140, 1'b1, 32'h500), 32'h140));
    vecs.push_back(row(32'h500));
    // flush collides with an allocating update
    vecs.push_back(tr(row(32'h140, 1'b1, 32'h500), 32'h140));
    vecs.push_back(fl(upd(row(32'h500), 32'h180, 1'b1, 32'h600)));
    vecs.push_back(tr(row(32'h140), 32'h140));
    vecs.push_back(tr(row(32'h180), 32'h180));
    vecs.push_back(row(32'h184));
    // reset mid-run drops redirect and update
    vecs.push_back(rst(tr(upd(row(RESET_PC), RESET_PC, 1'b1, 32'h700), 32'h900)));
    vecs.push_back(row(RESET_PC + 32'd4));
    // pc_plus4 wrap
    vecs.push_back(tr(row(32'hFFFF_FFFC), 32'hFFFF_FFFC));
    vecs.push_back(row(32'h0));
    // saturate at 11, then one not-taken still predicts taken; target overwrite
    vecs.push_back(upd(row(32'h4), 32'h10, 1'b1, 32'h40));
    vecs.push_back(upd(row(32'h8), 32'h10, 1'b1, 32'h40));
    vecs.push_back(upd(row(32'hC), 32'h10, 1'b1, 32'h40));
    vecs.push_back(upd(row(32'h10, 1'b1, 32'h40), 32'h10, 1'b0, 32'h0));
    vecs.push_back(row(32'h40));
    vecs.push_back(upd(row(32'h44), 32'h10, 1'b1, 32'h80));
    vecs.push_back(tr(row(32'h10, 1'b1, 32'h80), 32'h10));
    vecs.push_back(stl(row(32'h10, 1'b1, 32'h80)));
    vecs.push_back(row(32'h80));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // trap and EX together: the EX redirect is not replayed afterwards
    apply(exr(tr(row(32'h80), 32'h80), 32'h300), 100);
    apply(row(32'h84), 101);
    // EX correction overrides a live prediction at 0x10
    apply(tr(row(32'h10, 1'b1, 32'h80), 32'h10), 102);
    apply(exr(row(32'h14), 32'h14), 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
